dmem_responder: RTL



---
 rtl/dmem_responder_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/dmem_responder.sv | 89 ++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared width codes, MMIO offsets, STATUS bit indices and decode helpers
package dmem_responder_pkg;
  typedef enum logic [2:0] {
    W_B  = 3'b000,
    W_H  = 3'b001,
    W_W  = 3'b010,
    W_BU = 3'b100,
    W_HU = 3'b101
  } width_e;
  localparam logic [3:0] MMIO_TXDATA  = 4'h0;
  localparam logic [3:0] MMIO_STATUS  = 4'h4;
  localparam logic [3:0] MMIO_ERRADDR = 4'h8;
  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_MISALIGN = 3;
  localparam int ST_DECERR   = 4;
  function automatic logic misaligned(input logic [2:0] w, input logic [1:0] a);
    return (w == W_H || w == W_HU) ? a[0] : (w == W_W) ? (a != 2'b00) : !(w == W_B || w == W_BU);
  endfunction
  function automatic logic [31:0] width_mask(input logic [2:0] w);
    return (w == W_W) ? 32'hFFFF_FFFF : (w == W_H || w == W_HU) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered head (ports: clk_i, rst_i, push_i, pop_i, data_i, head_o, full_o, empty_o, count_o)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic push_ok, pop_ok;
  always_comb begin
    pop_ok  = pop_i & (cnt_q != '0);
    push_ok = push_i & ((cnt_q != CW'(DEPTH)) | pop_ok);
    rd_d    = rd_q + AW'(pop_ok);
    wr_d    = wr_q + AW'(push_ok);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    // when nothing older survives this cycle, the incoming byte becomes the head directly
    head_d  = (cnt_q == CW'(pop_ok)) ? (push_ok ? data_i : '0) : mem_q[rd_d];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
  assign head_o  = head_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: DMEM-side RAM plus MMIO (TX FIFO, STATUS, ERR_ADDR); core bus dmem_*, TX stream tx_*, err_o
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 14,
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE      = 32'h0800_0000,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  input  logic [2:0]  dmem_access_width_i,
  input  logic        dmem_we_i,
  output logic [31:0] dmem_data_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        err_o
);
  localparam int WORDS = 2 ** (MEM_ADDR_WIDTH - 2);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [31:0] ram_q [WORDS];
  logic [MEM_ADDR_WIDTH-3:0] idx;
  logic ram_hit, mmio_hit, mis, wr, dec, push, pop, st_wr, full, empty;
  logic [3:0] off, be;
  logic [CW-1:0] count;
  logic [31:0] ram_rd, mmio_rd, status, wdata;
  logic ovf_q, ovf_d, mis_q, mis_d, dec_q, dec_d;
  logic [31:0] err_addr_q, err_addr_d;
  always_comb begin
    idx      = dmem_addr_i[MEM_ADDR_WIDTH-1:2];
    off      = dmem_addr_i[3:0];
    ram_hit  = dmem_addr_i[31:MEM_ADDR_WIDTH] == MEM_BASE[31:MEM_ADDR_WIDTH];
    mmio_hit = dmem_addr_i[31:4] == MMIO_BASE[31:4];
    // MMIO registers are word-only, so narrower accesses there count as misaligned
    mis      = misaligned(dmem_access_width_i, dmem_addr_i[1:0]) | (mmio_hit & (dmem_access_width_i != W_W));
    wr       = dmem_we_i & !mis;
    dec      = wr & !ram_hit & !mmio_hit;
    push     = wr & mmio_hit & (off == MMIO_TXDATA);
    st_wr    = wr & mmio_hit & (off == MMIO_STATUS);
    pop      = tx_valid_o & tx_ready_i;
    status   = {16'd0, 8'(count), 3'd0, dec_q, mis_q, ovf_q, full, empty};
    ram_rd   = ram_q[idx] >> {dmem_addr_i[1:0], 3'b000};
    mmio_rd  = (off == MMIO_STATUS) ? status : (off == MMIO_ERRADDR) ? err_addr_q : 32'd0;
    dmem_data_o = mis ? 32'd0 : (ram_hit ? ram_rd : mmio_hit ? mmio_rd : 32'd0) & width_mask(dmem_access_width_i);
    be       = (dmem_access_width_i == W_W) ? 4'hF :
               (dmem_access_width_i == W_H || dmem_access_width_i == W_HU) ? 4'h3 << dmem_addr_i[1:0] :
               4'h1 << dmem_addr_i[1:0];
    wdata    = dmem_data_i << {dmem_addr_i[1:0], 3'b000};
    // a new error in the same cycle as its write-1-to-clear wins
    ovf_d    = (ovf_q & !(st_wr & dmem_data_i[ST_OVF])) | (push & full & !pop);
    mis_d    = (mis_q & !(st_wr & dmem_data_i[ST_MISALIGN])) | mis;
    dec_d    = (dec_q & !(st_wr & dmem_data_i[ST_DECERR])) | dec;
    err_addr_d = ((mis | dec) & !mis_q & !dec_q) ? dmem_addr_i : err_addr_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q      <= 1'b0;
      mis_q      <= 1'b0;
      dec_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      ovf_q      <= ovf_d;
      mis_q      <= mis_d;
      dec_q      <= dec_d;
      err_addr_q <= err_addr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr & ram_hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram_q[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (dmem_data_i[7:0]),
    .head_o  (tx_data_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign tx_valid_o = !empty;
  assign err_o = ovf_q | mis_q | dec_q;
endmodule
